// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_pkg
//  Brief    : Shared constants and types for the external-interrupt
//             controller (register map, claim word layout).
//  Revision : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 5;

  // Register index map of the ce/we register port
  typedef enum logic [ADDR_W-1:0] {
    REG_PENDING = 3'd0,
    REG_MASK    = 3'd1,
    REG_MODE    = 3'd2,
    REG_CLAIM   = 3'd3,
    REG_RAW     = 3'd4
  } reg_addr_e;

  // Result of the lowest-index priority search
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } claim_t;

  // Claim word as seen by software: {valid, 26'b0, id}
  function automatic logic [DATA_W-1:0] pack_claim(input claim_t c);
    return {c.valid, 26'b0, c.id};
  endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_sync.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl_sync
//  Brief    : WIDTH-bit, STAGES-deep flop-chain synchroniser for the raw
//             interrupt inputs, asynchronous active-high reset.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl_sync #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] chain_q [STAGES];

  // Shift each input bit through STAGES flops; stage 0 samples the raw input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) chain_q[k] <= '0;
    end else begin
      chain_q[0] <= d_i;
      for (int k = 1; k < STAGES; k++) chain_q[k] <= chain_q[k-1];
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : irq_ctrl
//  Brief    : External-interrupt controller. Per-source level/rising-edge
//             mode, pending latch and mask, folded onto N_OUT CPU lines,
//             with a 1-cycle register port and a CLAIM register.
//  Config   : IRQ_CTRL_SYNC_EN - when defined, irq_i passes through a
//             SYNC_STAGES-deep synchroniser; otherwise irq_i is used as-is
//             and must already be synchronous to clk.
//  Revision : 1.0 - initial release
// ============================================================================
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC       = 16,
  parameter int N_OUT       = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_i,
  input  logic             ce_i,
  input  logic             we_i,
  input  logic [2:0]       addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o,
  output logic [N_OUT-1:0] int_o
);

  logic [N_SRC-1:0] sync_irq;

`ifdef IRQ_CTRL_SYNC_EN
  irq_ctrl_sync #(
    .WIDTH  (N_SRC),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (irq_i),
    .q_o (sync_irq)
  );
`else
  assign sync_irq = irq_i;
  logic unused_sync_cfg;
  assign unused_sync_cfg = ^SYNC_STAGES;
`endif

  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] prev_q;
  logic [N_OUT-1:0] int_q, int_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             rd_en, wr_en;
  logic [N_SRC-1:0] wdata_src;
  logic [N_SRC-1:0] active;
  claim_t           claim;
  logic             claim_take;
  logic [N_SRC-1:0] edge_set, edge_clr, mode_chg;
  logic             unused_wdata;

  assign rd_en        = ce_i & ~we_i;
  assign wr_en        = ce_i & we_i;
  assign wdata_src    = wdata_i[N_SRC-1:0];
  assign unused_wdata = ^wdata_i;
  assign active       = pend_q & mask_q;

  // Lowest-index pending-and-enabled source wins the claim
  always_comb begin
    claim = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim.valid = 1'b1;
        claim.id    = ID_W'(i);
      end
    end
  end

  assign claim_take = rd_en && (addr_i == REG_CLAIM) && claim.valid;

  // Edge sources set on a synced rising edge and clear by W1C or a claim;
  // the set term is OR-ed last so a coincident edge survives the clear.
  // A mode change drops the pending bit regardless of either mode's rule.
  always_comb begin
    edge_set = sync_irq & ~prev_q;
    edge_clr = (wr_en && addr_i == REG_PENDING) ? wdata_src : '0;
    if (claim_take) edge_clr = edge_clr | (N_SRC'(1'b1) << claim.id);
    mode_chg = (wr_en && addr_i == REG_MODE) ? (wdata_src ^ mode_q) : '0;
    pend_d   = ((~mode_q & sync_irq) |
                (mode_q & (edge_set | (pend_q & ~edge_clr)))) & ~mode_chg;
  end

  // Control register writes
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    if (wr_en && addr_i == REG_MASK) mask_d = wdata_src;
    if (wr_en && addr_i == REG_MODE) mode_d = wdata_src;
  end

  // Fold enabled pending sources onto CPU lines: source i drives line i%N_OUT
  always_comb begin
    int_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      int_d[i % N_OUT] = int_d[i % N_OUT] | active[i];
    end
  end

  // Read mux; the registered read data holds until the next read
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = '0;
      case (addr_i)
        REG_PENDING: rdata_d[N_SRC-1:0] = pend_q;
        REG_MASK:    rdata_d[N_SRC-1:0] = mask_q;
        REG_MODE:    rdata_d[N_SRC-1:0] = mode_q;
        REG_CLAIM:   rdata_d            = pack_claim(claim);
        REG_RAW:     rdata_d[N_SRC-1:0] = sync_irq;
        default:     rdata_d            = '0;
      endcase
    end
  end

  // State registers, all cleared immediately by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      prev_q  <= '0;
      int_q   <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      prev_q  <= sync_irq;
      int_q   <= int_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign int_o   = int_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_irq_ctrl
//  Brief    : Scoreboard bench for irq_ctrl: a behavioural model predicts
//             int_o every cycle and rdata_o after every read; a monitor
//             pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

  localparam int N_SRC       = 16;
  localparam int N_OUT       = 6;
  localparam int SYNC_STAGES = 2;
`ifdef IRQ_CTRL_SYNC_EN
  localparam int LAT = SYNC_STAGES;
`else
  localparam int LAT = 0;
`endif
  localparam bit [31:0] SRC_MASK = 32'hFFFF_FFFF >> (32 - N_SRC);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_SRC-1:0] irq_i = '0;
  logic             ce_i = 1'b0;
  logic             we_i = 1'b0;
  logic [2:0]       addr_i = '0;
  logic [31:0]      wdata_i = '0;
  logic [31:0]      rdata_o;
  logic [N_OUT-1:0] int_o;

  irq_ctrl #(
    .N_SRC       (N_SRC),
    .N_OUT       (N_OUT),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .irq_i   (irq_i),
    .ce_i    (ce_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .int_o   (int_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  bit started = 1'b0;

  logic [31:0]      rd_q  [$];
  logic [N_OUT-1:0] int_q [$];

  // Behavioural model: whole-register view of the controller
  bit [31:0] m_pend, m_mask, m_mode, m_prev;
  bit [31:0] m_pipe [$];

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_pend = 0; m_mask = 0; m_mode = 0; m_prev = 0;
    m_pipe.delete();
    for (int k = 0; k < LAT; k++) m_pipe.push_back(32'd0);
  endfunction

  // One clock edge of the model: predicts read data and next int_o
  function automatic void model_edge(input bit [31:0] irq, input bit ce, input bit we,
                                     input bit [2:0] a, input bit [31:0] wd);
    bit [31:0]      s, act, nxt, rv;
    bit [N_OUT-1:0] lines;
    bit             valid;
    int             id;
    if (LAT == 0) s = irq;
    else begin
      s = m_pipe.pop_front();
      m_pipe.push_back(irq);
    end
    act = m_pend & m_mask;
    valid = 0; id = 0;
    for (int i = 0; i < N_SRC; i++)
      if (act[i] && !valid) begin valid = 1; id = i; end
    if (ce && !we) begin
      case (a)
        3'd0: rv = m_pend;
        3'd1: rv = m_mask;
        3'd2: rv = m_mode;
        3'd3: rv = valid ? (32'h8000_0000 + 32'(id)) : 32'd0;
        3'd4: rv = s;
        default: rv = 32'd0;
      endcase
      rd_q.push_back(rv);
    end
    lines = '0;
    for (int i = 0; i < N_SRC; i++) if (act[i]) lines[i % N_OUT] = 1'b1;
    int_q.push_back(lines);
    nxt = 0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ce && we && a == 3'd2 && wd[i] != m_mode[i]) nxt[i] = 0;
      else if (!m_mode[i]) nxt[i] = s[i];
      else if (s[i] && !m_prev[i]) nxt[i] = 1;
      else if ((ce && we && a == 3'd0 && wd[i]) ||
               (ce && !we && a == 3'd3 && valid && id == i)) nxt[i] = 0;
      else nxt[i] = m_pend[i];
    end
    m_prev = s;
    if (ce && we && a == 3'd1) m_mask = wd & SRC_MASK;
    if (ce && we && a == 3'd2) m_mode = wd & SRC_MASK;
    m_pend = nxt;
  endfunction

  // Apply one cycle of stimulus and advance the model at the same edge
  task automatic tick(input logic [N_SRC-1:0] irq, input logic ce, input logic we,
                      input logic [2:0] a, input logic [31:0] wd);
    @(negedge clk);
    irq_i = irq; ce_i = ce; we_i = we; addr_i = a; wdata_i = wd;
    started = 1'b1;
    @(posedge clk);
    if (rst) int_q.push_back('0);
    else model_edge(32'(irq), ce, we, a, wd);
  endtask

  task automatic idle(input logic [N_SRC-1:0] irq, input int n);
    for (int k = 0; k < n; k++) tick(irq, 1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [N_SRC-1:0] irq, input logic [2:0] a);
    tick(irq, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic wr(input logic [N_SRC-1:0] irq, input logic [2:0] a, input logic [31:0] d);
    tick(irq, 1'b1, 1'b1, a, d);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    check("rst_int_o", 32'(int_o), 32'd0);
    check("rst_rdata_o", rdata_o, 32'd0);
    model_reset();
    idle('1, 2);
    #2 rst = 1'b0;
  endtask

  // Monitor: int_o every edge, rdata_o after every edge that performed a read
  initial begin
    logic rd_seen;
    wait (started);
    forever begin
      @(posedge clk);
      rd_seen = ce_i && !we_i && !rst;
      #1;
      if (int_q.size() == 0) check("int_q_underflow", 32'd1, 32'd0);
      else check("int_o", 32'(int_o), 32'(int_q.pop_front()));
      if (rd_seen) begin
        if (rd_q.size() == 0) check("rd_q_underflow", 32'd1, 32'd0);
        else check("rdata_o", rdata_o, rd_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks passed", n_pass);
    $fatal(1);
  end

  initial begin
    logic [N_SRC-1:0] cur;
    logic [2:0]       a;
    int               op;
    model_reset();
    #1;
    check("reset_int_o", 32'(int_o), 32'd0);
    check("reset_rdata_o", rdata_o, 32'd0);
    idle('0, 2);
    #2 rst = 1'b0;

    // Reset mid-pulse with everything enabled, then PENDING re-syncs
    wr('1, 3'd1, 32'hFFFF_FFFF);
    idle('1, LAT + 3);
    async_reset();
    rd('1, 3'd0);
    rd('1, 3'd0);
    idle('1, LAT + 2);
    rd('1, 3'd0);
    idle('0, LAT + 3);

    // Level source 3 rise and fall latency
    wr('0, 3'd1, 32'h8);
    idle(N_SRC'(16'h0008), LAT + 3);
    rd(N_SRC'(16'h0008), 3'd4);
    idle('0, LAT + 3);

    // Edge source 7: pulse, read, W1C
    wr('0, 3'd2, 32'h80);
    wr('0, 3'd1, 32'h80);
    idle(N_SRC'(16'h0080), 1);
    idle('0, LAT + 2);
    rd('0, 3'd0);
    wr('0, 3'd0, 32'h80);
    rd('0, 3'd0);
    idle('0, 2);

    // Claim order for edge sources 2 and 9
    wr('0, 3'd2, 32'h204);
    wr('0, 3'd1, 32'h204);
    idle(N_SRC'(16'h0204), 1);
    idle('0, LAT + 2);
    rd('0, 3'd3);
    rd('0, 3'd3);
    rd('0, 3'd3);
    idle('0, 2);

    // Set/clear collision on edge source 5
    wr('0, 3'd2, 32'h20);
    wr('0, 3'd1, 32'h20);
    idle(N_SRC'(16'h0020), 1);
    idle('0, LAT + 2);
    idle(N_SRC'(16'h0020), LAT);
    wr(N_SRC'(16'h0020), 3'd0, 32'h20);
    rd(N_SRC'(16'h0020), 3'd0);
    idle('0, 2);

    // Masked level source 0, then flip it to edge mode
    wr('0, 3'd2, 32'h0);
    wr('0, 3'd1, 32'h0);
    idle(N_SRC'(16'h0001), LAT + 2);
    rd(N_SRC'(16'h0001), 3'd3);
    rd(N_SRC'(16'h0001), 3'd0);
    wr(N_SRC'(16'h0001), 3'd2, 32'h1);
    rd(N_SRC'(16'h0001), 3'd0);
    rd(N_SRC'(16'h0001), 3'd2);
    idle('0, 2);

    // Randomised traffic with one reset in the middle
    cur = '0;
    for (int n = 0; n < 400; n++) begin
      if (n == 200) async_reset();
      cur = cur ^ (N_SRC'($urandom) & N_SRC'($urandom) & N_SRC'($urandom));
      op  = int'($urandom_range(0, 9));
      a   = 3'($urandom_range(0, 7));
      if (op < 5)      idle(cur, 1);
      else if (op < 8) rd(cur, a);
      else             wr(cur, a, $urandom);
    end
    idle('0, LAT + 3);

    #4;
    check("queues_drained", 32'(int_q.size() + rd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
`default_nettype wire
